avalon_mem_arbiter: RTL and testbench

- Shares the core's single Avalon-MM master between two requesters: instruction fetch (IF) and the memory stage (DM, driven by the mem_read/mem_write controls).
- Sequences one transaction at a time with a state machine and generates per-requester stall signals for the hazard logic.
- Returns read data with a one-cycle valid pulse.
- Sits between the pipeline stages and the system interconnect.

---
 rtl/avalon_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_avalon_mem_arbiter.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_arbiter.sv
// Shares the core's single Avalon-MM master between instruction fetch and the memory stage.
// Define ARB_PERF_CNT_EN to add saturating per-requester stall counters.
module avalon_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]         if_stall_cnt,
    output logic [31:0]         dm_stall_cnt,
`endif
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                dm_read,
    input  logic                dm_write,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_byteenable,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_CMD,
        S_IF_RESP,
        S_DM_RD_CMD,
        S_DM_RD_RESP,
        S_DM_WR_CMD
    } state_t;

    state_t              state_q;
    logic                last_dm_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                read_q;
    logic                write_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                if_valid_q;
    logic                dm_valid_q;

    logic                if_pend;
    logic                dm_pend;
    logic                grant_if_d;
    logic                grant_dm_d;

    // A requester whose valid is pulsing this cycle has already been served and is not re-arbitrated yet.
    always_comb begin
        if_pend    = if_req & ~if_valid_q;
        dm_pend    = (dm_read | dm_write) & ~dm_valid_q;
        grant_dm_d = dm_pend & (~if_pend | ~last_dm_q);
        grant_if_d = if_pend & ~grant_dm_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_dm_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_dm_d) begin
                        addr_q    <= dm_addr;
                        last_dm_q <= 1'b1;
                        if (dm_write) begin
                            wdata_q <= dm_wdata;
                            be_q    <= dm_byteenable;
                            write_q <= 1'b1;
                            state_q <= S_DM_WR_CMD;
                        end else begin
                            be_q    <= '1;
                            read_q  <= 1'b1;
                            state_q <= S_DM_RD_CMD;
                        end
                    end else if (grant_if_d) begin
                        addr_q    <= if_addr;
                        be_q      <= '1;
                        read_q    <= 1'b1;
                        last_dm_q <= 1'b0;
                        state_q   <= S_IF_CMD;
                    end
                end
                S_IF_CMD: begin
                    if (!avm_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= S_IF_RESP;
                    end
                end
                S_DM_RD_CMD: begin
                    if (!avm_waitrequest) begin
                        read_q  <= 1'b0;
                        state_q <= S_DM_RD_RESP;
                    end
                end
                S_DM_WR_CMD: begin
                    if (!avm_waitrequest) begin
                        write_q    <= 1'b0;
                        dm_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_IF_RESP: begin
                    if (avm_readdatavalid) begin
                        if_rdata_q <= avm_readdata;
                        if_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_DM_RD_RESP: begin
                    if (avm_readdatavalid) begin
                        dm_rdata_q <= avm_readdata;
                        dm_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign if_rdata       = if_rdata_q;
    assign dm_rdata       = dm_rdata_q;
    assign if_valid       = if_valid_q;
    assign dm_valid       = dm_valid_q;
    assign if_stall       = if_req & ~if_valid_q;
    assign dm_stall       = (dm_read | dm_write) & ~dm_valid_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt_q;
    logic [31:0] dm_stall_cnt_q;

    // Counters stick at all-ones rather than wrapping so long stalls stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_stall_cnt_q <= '0;
            dm_stall_cnt_q <= '0;
        end else begin
            if (if_stall && (if_stall_cnt_q != 32'hFFFF_FFFF)) begin
                if_stall_cnt_q <= if_stall_cnt_q + 32'd1;
            end
            if (dm_stall && (dm_stall_cnt_q != 32'hFFFF_FFFF)) begin
                dm_stall_cnt_q <= dm_stall_cnt_q + 32'd1;
            end
        end
    end

    assign if_stall_cnt = if_stall_cnt_q;
    assign dm_stall_cnt = dm_stall_cnt_q;
`endif

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (service order, memory contents, Avalon commands).
module tb_avalon_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_byteenable;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_stall;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [BE_W-1:0]   avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       if_stall_cnt;
    logic [31:0]       dm_stall_cnt;
`endif

    // Avalon inputs come either from the scripted driver or from the reactive slave model
    logic        useMan;
    logic        manWait;
    logic        manRdv;
    logic [31:0] manRdata;
    logic        slvWait;
    logic        slvRdv;
    logic [31:0] slvRdata;

    assign avm_waitrequest   = useMan ? manWait  : slvWait;
    assign avm_readdatavalid = useMan ? manRdv   : slvRdv;
    assign avm_readdata      = useMan ? manRdata : slvRdata;

    int          checks = 0;
    int          errors = 0;
    int          slaveWait = 0;
    int          slaveLat = 1;
    bit          overlapSeen = 1'b0;
    cmd_t        slvLog[$];
    logic [31:0] slvMem[16];
    logic [31:0] modelMem[16];
    logic        modelLastDm;
    logic [31:0] ifQ[$];
    cmd_t        dmQ[$];

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef ARB_PERF_CNT_EN
        .if_stall_cnt      (if_stall_cnt),
        .dm_stall_cnt      (dm_stall_cnt),
`endif
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_rdata          (if_rdata),
        .if_valid          (if_valid),
        .if_stall          (if_stall),
        .dm_read           (dm_read),
        .dm_write          (dm_write),
        .dm_addr           (dm_addr),
        .dm_wdata          (dm_wdata),
        .dm_byteenable     (dm_byteenable),
        .dm_rdata          (dm_rdata),
        .dm_valid          (dm_valid),
        .dm_stall          (dm_stall),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    // Reactive Avalon slave: programmable waitrequest count and read latency, word memory
    initial begin : slaveModel
        int         waitCnt;
        int         respAge;
        bit         respPending;
        logic [3:0] respIdx;
        logic [3:0] wIdx;
        for (int i = 0; i < 16; i++) slvMem[i] = 32'hA500_0000 + i * 32'h0001_0101;
        slvWait = 1'b0;
        slvRdv = 1'b0;
        slvRdata = '0;
        waitCnt = 0;
        respAge = 0;
        respPending = 1'b0;
        respIdx = '0;
        forever begin
            @(posedge clk);
            #1;
            slvRdv = 1'b0;
            if (useMan || !rst_n) begin
                waitCnt = 0;
                respPending = 1'b0;
                slvWait = 1'b0;
            end else begin
                if (avm_read && avm_write) overlapSeen = 1'b1;
                if (respPending) begin
                    respAge++;
                    if (respAge >= slaveLat) begin
                        slvRdv = 1'b1;
                        slvRdata = slvMem[respIdx];
                        respPending = 1'b0;
                    end
                end
                if (avm_read || avm_write) begin
                    if (respPending) overlapSeen = 1'b1;
                    if (waitCnt < slaveWait) begin
                        slvWait = 1'b1;
                        waitCnt++;
                    end else begin
                        slvWait = 1'b0;
                        waitCnt = 0;
                        slvLog.push_back('{avm_write, avm_address, avm_writedata, avm_byteenable});
                        if (avm_write) begin
                            wIdx = avm_address[5:2];
                            for (int b = 0; b < 4; b++)
                                if (avm_byteenable[b]) slvMem[wIdx][8*b +: 8] = avm_writedata[8*b +: 8];
                        end else begin
                            respPending = 1'b1;
                            respAge = 0;
                            respIdx = avm_address[5:2];
                        end
                    end
                end else begin
                    slvWait = 1'b0;
                    waitCnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_avm_read"},       avm_read, 0);
        checkOutput({tag, "_avm_write"},      avm_write, 0);
        checkOutput({tag, "_avm_address"},    avm_address, 0);
        checkOutput({tag, "_avm_writedata"},  avm_writedata, 0);
        checkOutput({tag, "_avm_byteenable"}, avm_byteenable, 0);
        checkOutput({tag, "_if_rdata"},       if_rdata, 0);
        checkOutput({tag, "_dm_rdata"},       dm_rdata, 0);
        checkOutput({tag, "_if_valid"},       if_valid, 0);
        checkOutput({tag, "_dm_valid"},       dm_valid, 0);
    endtask

    function automatic void modelWrite(input cmd_t op);
        logic [3:0] idx;
        idx = op.addr[5:2];
        for (int b = 0; b < 4; b++)
            if (op.be[b]) modelMem[idx][8*b +: 8] = op.data[8*b +: 8];
    endfunction

    task automatic driveIf(input int idx);
        if (idx < ifQ.size()) begin
            if_req = 1'b1;
            if_addr = ifQ[idx];
        end else begin
            if_req = 1'b0;
        end
    endtask

    task automatic driveDm(input int idx);
        if (idx < dmQ.size()) begin
            dm_write = dmQ[idx].wr;
            dm_read = ~dmQ[idx].wr;
            dm_addr = dmQ[idx].addr;
            dm_wdata = dmQ[idx].data;
            dm_byteenable = dmQ[idx].be;
        end else begin
            dm_write = 1'b0;
            dm_read = 1'b0;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0; dm_byteenable = '0;
        useMan = 1'b1; manWait = 1'b0; manRdv = 1'b0; manRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        checkOutput("reset_if_stall", if_stall, 0);
        checkOutput("reset_dm_stall", dm_stall, 0);
`ifdef ARB_PERF_CNT_EN
        checkOutput("reset_if_stall_cnt", if_stall_cnt, 0);
        checkOutput("reset_dm_stall_cnt", dm_stall_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        modelLastDm = 1'b1;
    endtask

    // Both requesters issue their queues back to back; the model predicts service order and data
    task automatic applyStimulus(input string tag);
        logic [31:0] expIf[$];
        logic [31:0] expDm[$];
        cmd_t        expCmd[$];
        cmd_t        op;
        logic [3:0]  idx;
        logic        lastDm;
        bit          pickDm;
        int          ni, nd, base, cyc, limit, ifIdx, dmIdx;
        ni = 0; nd = 0;
        lastDm = modelLastDm;
        while (ni < ifQ.size() || nd < dmQ.size()) begin
            if (ni < ifQ.size() && nd < dmQ.size()) pickDm = ~lastDm;
            else pickDm = (nd < dmQ.size());
            if (pickDm) begin
                op = dmQ[nd];
                nd++;
                expCmd.push_back(op);
                if (op.wr) modelWrite(op);
                else begin
                    idx = op.addr[5:2];
                    expDm.push_back(modelMem[idx]);
                end
                lastDm = 1'b1;
            end else begin
                op.wr = 1'b0; op.addr = ifQ[ni]; op.data = '0; op.be = '0;
                idx = op.addr[5:2];
                expIf.push_back(modelMem[idx]);
                expCmd.push_back(op);
                ni++;
                lastDm = 1'b0;
            end
        end
        modelLastDm = lastDm;

        useMan = 1'b0;
        base = slvLog.size();
        limit = 40 * (ifQ.size() + dmQ.size() + 1);
        ifIdx = 0; dmIdx = 0; cyc = 0;
        tick();
        driveIf(0);
        driveDm(0);
        while ((ifIdx < ifQ.size() || dmIdx < dmQ.size()) && cyc < limit) begin
            tick();
            cyc++;
            if (if_valid) begin
                if (ifIdx < ifQ.size()) checkOutput({tag, "_if_rdata"}, if_rdata, expIf[ifIdx]);
                else checkOutput({tag, "_if_extra_valid"}, 1, 0);
                ifIdx++;
                driveIf(ifIdx);
            end
            if (dm_valid) begin
                if (dmIdx < dmQ.size()) begin
                    if (!dmQ[dmIdx].wr) begin
                        checkOutput({tag, "_dm_rdata"}, dm_rdata, expDm[0]);
                        void'(expDm.pop_front());
                    end
                end else begin
                    checkOutput({tag, "_dm_extra_valid"}, 1, 0);
                end
                dmIdx++;
                driveDm(dmIdx);
            end
        end
        checkOutput({tag, "_all_served"}, (ifIdx == ifQ.size()) && (dmIdx == dmQ.size()), 1);
        tick();
        checkOutput({tag, "_no_extra_valid"}, {if_valid, dm_valid}, 0);
        checkOutput({tag, "_cmd_count"}, slvLog.size() - base, expCmd.size());
        for (int i = 0; i < expCmd.size(); i++) begin
            if (base + i < slvLog.size()) begin
                checkOutput({tag, "_cmd_addr"}, slvLog[base+i].addr, expCmd[i].addr);
                checkOutput({tag, "_cmd_wr"}, slvLog[base+i].wr, expCmd[i].wr);
                if (expCmd[i].wr) begin
                    checkOutput({tag, "_cmd_wdata"}, slvLog[base+i].data, expCmd[i].data);
                    checkOutput({tag, "_cmd_be"}, slvLog[base+i].be, expCmd[i].be);
                end
            end
        end
    endtask

    initial begin : mainSeq
        int          readCycles, writeCycles, stallCycles, validCycle, validCount;
        int          earlyValid, rdataChanged, dmChanged, unstable, readSeen, strobeSeen;
        bit          prevAccept, gotValid;
        logic [31:0] firstAddr, capData;
        cmd_t        op;
        int          nIf, nDm;

        for (int i = 0; i < 16; i++) modelMem[i] = 32'hA500_0000 + i * 32'h0001_0101;
        resetDut();

        // Fetch only, zero wait, data one cycle after accept
        readCycles = 0; writeCycles = 0; stallCycles = 0; validCycle = -1; validCount = 0;
        firstAddr = '0; capData = '0; prevAccept = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            manRdv = prevAccept;
            manRdata = prevAccept ? 32'hDEAD_BEEF : 32'h0;
            if (c == 0) begin
                if_req = 1'b1;
                if_addr = 32'h100;
            end
            if (if_valid) begin
                validCount++;
                if (validCycle < 0) validCycle = c;
                capData = if_rdata;
                if_req = 1'b0;
            end
            #1;
            if (avm_read) begin
                readCycles++;
                if (readCycles == 1) firstAddr = avm_address;
            end
            if (avm_write) writeCycles++;
            if (if_stall) stallCycles++;
            prevAccept = avm_read & ~avm_waitrequest;
        end
        checkOutput("fetch_read_cycles", readCycles, 1);
        checkOutput("fetch_address", firstAddr, 32'h100);
        checkOutput("fetch_no_write", writeCycles, 0);
        checkOutput("fetch_valid_cycle", validCycle, 3);
        checkOutput("fetch_valid_count", validCount, 1);
        checkOutput("fetch_rdata", capData, 32'hDEAD_BEEF);
        checkOutput("fetch_stall_cycles", stallCycles, 3);
`ifdef ARB_PERF_CNT_EN
        checkOutput("fetch_if_stall_cnt", if_stall_cnt, 3);
        checkOutput("fetch_dm_stall_cnt", dm_stall_cnt, 0);
`endif
        modelLastDm = 1'b0;

        // Spurious readdatavalid while idle and during a stretched command phase
        earlyValid = 0; rdataChanged = 0; dmChanged = 0; gotValid = 1'b0; capData = '0;
        for (int c = 0; c < 11; c++) begin
            tick();
            manRdv = (c <= 8);
            manRdata = (c == 8) ? 32'h0000_C0DE : 32'hBAD0_BAD0;
            manWait = (c >= 4 && c <= 6);
            if (c == 3) begin
                if_req = 1'b1;
                if_addr = 32'h40;
            end
            if ((if_valid || dm_valid) && c != 9) earlyValid++;
            if (c == 9 && if_valid) begin
                gotValid = 1'b1;
                capData = if_rdata;
                if_req = 1'b0;
            end
            if (c <= 8 && if_rdata !== 32'hDEAD_BEEF) rdataChanged++;
            if (dm_rdata !== 32'h0) dmChanged++;
        end
        manRdv = 1'b0;
        manWait = 1'b0;
        checkOutput("spurious_no_valid", earlyValid, 0);
        checkOutput("spurious_rdata_held", rdataChanged, 0);
        checkOutput("spurious_dm_rdata_held", dmChanged, 0);
        checkOutput("spurious_real_valid", gotValid, 1);
        checkOutput("spurious_real_rdata", capData, 32'h0000_C0DE);
        modelLastDm = 1'b0;

        // Reset while a DM read waits for its response
        tick();
        dm_read = 1'b1;
        dm_addr = 32'h3000;
        tick();
        checkOutput("midrst_cmd_read", avm_read, 1);
        tick();
        checkOutput("midrst_resp_read_low", avm_read, 0);
        rst_n = 1'b0;
        dm_read = 1'b0;
        #1;
        checkAllZero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        modelLastDm = 1'b1;
        readSeen = 0; strobeSeen = 0; dmChanged = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            manRdv = (c < 2);
            manRdata = 32'h7777_7777;
            #1;
            if (dm_valid || if_valid) readSeen++;
            if (avm_read || avm_write) strobeSeen++;
            if (dm_rdata !== 32'h0) dmChanged++;
        end
        manRdv = 1'b0;
        checkOutput("midrst_no_valid", readSeen, 0);
        checkOutput("midrst_no_strobe", strobeSeen, 0);
        checkOutput("midrst_dm_rdata_zero", dmChanged, 0);
`ifdef ARB_PERF_CNT_EN
        checkOutput("midrst_dm_stall_cnt", dm_stall_cnt, 0);
`endif

        // Simultaneous IF and DM reads after reset: IF first, then strict alternation
        slaveWait = 0;
        slaveLat = 1;
        ifQ.delete();
        dmQ.delete();
        for (int i = 0; i < 4; i++) begin
            ifQ.push_back(32'h0 + i * 4);
            op.wr = 1'b0; op.addr = 32'h1010 + i * 4; op.data = '0; op.be = 4'hF;
            dmQ.push_back(op);
        end
        applyStimulus("alternate");

        // Data write held off by two waitrequest cycles
        useMan = 1'b0;
        slaveWait = 2;
        slaveLat = 1;
        writeCycles = 0; unstable = 0; validCycle = -1; validCount = 0; readSeen = 0; stallCycles = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) begin
                dm_write = 1'b1;
                dm_read = 1'b0;
                dm_addr = 32'h2000;
                dm_wdata = 32'h1234_5678;
                dm_byteenable = 4'hF;
            end
            if (dm_valid) begin
                validCount++;
                if (validCycle < 0) validCycle = c;
                dm_write = 1'b0;
            end
            #1;
            if (avm_write) begin
                writeCycles++;
                if (avm_address !== 32'h2000 || avm_writedata !== 32'h1234_5678 || avm_byteenable !== 4'hF)
                    unstable++;
            end
            if (avm_read) readSeen++;
            if (dm_stall) stallCycles++;
        end
        checkOutput("write_strobe_cycles", writeCycles, 3);
        checkOutput("write_signals_stable", unstable, 0);
        checkOutput("write_valid_cycle", validCycle, 4);
        checkOutput("write_valid_count", validCount, 1);
        checkOutput("write_no_read", readSeen, 0);
        checkOutput("write_stall_cycles", stallCycles, 4);
        op.wr = 1'b1; op.addr = 32'h2000; op.data = 32'h1234_5678; op.be = 4'hF;
        modelWrite(op);
        modelLastDm = 1'b1;

        // Randomized mixes of fetches, loads and byte-masked stores
        for (int r = 0; r < 8; r++) begin
            slaveWait = $urandom_range(0, 2);
            slaveLat = $urandom_range(1, 3);
            ifQ.delete();
            dmQ.delete();
            nIf = $urandom_range(0, 4);
            nDm = $urandom_range(0, 4);
            if (nIf + nDm == 0) nIf = 1;
            for (int i = 0; i < nIf; i++) ifQ.push_back($urandom_range(0, 15) * 4);
            for (int i = 0; i < nDm; i++) begin
                op.wr = $urandom_range(0, 1);
                op.addr = 32'h1000 + $urandom_range(0, 15) * 4;
                op.data = $urandom;
                op.be = $urandom_range(1, 15);
                dmQ.push_back(op);
            end
            applyStimulus("random");
        end

        checkOutput("avm_single_outstanding", overlapSeen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
